sim_run_ctrl: RTL and testbench

//  Run controller between the top-level bench clock source and tb_top.

---
 rtl/sim_run_pkg.sv | 20 ++
 rtl/sat_up_counter.sv | 25 ++
 rtl/sim_run_ctrl.sv | 116 +++++++++++
 tb/tb_sim_run_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sim_run_pkg.sv
// Shared types and default parameters for the simulation run controller.
// The defaults are exported so benches can size their own expectations from them.
package sim_run_pkg;

  typedef enum logic [2:0] {
    HOLD,
    RUN,
    PASS,
    FAIL,
    TIMEOUT
  } run_state_t;

  localparam int RUN_RST_CYCLES     = 10;
  localparam int RUN_TIMEOUT_CYCLES = 20;

  function automatic logic is_terminal(run_state_t s);
    return (s == PASS) || (s == FAIL) || (s == TIMEOUT);
  endfunction

endpackage

// File: rtl/sat_up_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Once it reaches MAX it holds there until rst or clr.
module sat_up_counter #(
  parameter int W   = 8,
  parameter int MAX = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  assign at_max = (cnt == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !at_max) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: holds the DUT in reset, counts run cycles, and latches a
// sticky PASS/FAIL/TIMEOUT verdict until the next rst.
module sim_run_ctrl #(
  parameter int RST_CYCLES     = sim_run_pkg::RUN_RST_CYCLES,
  parameter int TIMEOUT_CYCLES = sim_run_pkg::RUN_TIMEOUT_CYCLES,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done_i,
  input  logic             fail_i,
  output logic             dut_rst_n,
  output logic             running,
  output logic             finished,
  output logic             passed,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt
);

  import sim_run_pkg::*;

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  run_state_t        state;
  run_state_t        next_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_at_max;
  logic              hold_en;
  logic              cycle_en;
  logic              cycle_at_max;
  logic              hold_last;
  logic              run_last;

  // The hold counter saturates at RST_CYCLES-1, which is exactly the release edge.
  sat_up_counter #(
    .W   (HOLD_W),
    .MAX (RST_CYCLES - 1)
  ) u_hold_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (1'b0),
    .en     (hold_en),
    .cnt    (hold_cnt),
    .at_max (hold_at_max)
  );

  sat_up_counter #(
    .W   (CNT_W),
    .MAX (TIMEOUT_CYCLES)
  ) u_cycle_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (1'b0),
    .en     (cycle_en),
    .cnt    (cycle_cnt),
    .at_max (cycle_at_max)
  );

  assign hold_last = (hold_cnt == HOLD_W'(RST_CYCLES - 1));
  assign run_last  = (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign hold_en   = (state == HOLD) && !hold_at_max;
  // The edge that enters PASS or FAIL must not count as a run cycle.
  assign cycle_en  = (state == RUN) && !fail_i && !done_i && !cycle_at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HOLD;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      HOLD: begin
        if (hold_last) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (fail_i) begin
          next_state = FAIL;
        end else if (done_i) begin
          next_state = PASS;
        end else if (run_last) begin
          next_state = TIMEOUT;
        end
      end
      PASS, FAIL, TIMEOUT: begin
        next_state = state;
      end
      default: begin
        next_state = HOLD;
      end
    endcase
  end

  // Flags are registered from next_state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_rst_n <= 1'b0;
      running   <= 1'b0;
      finished  <= 1'b0;
      passed    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      dut_rst_n <= (next_state != HOLD);
      running   <= (next_state == RUN);
      finished  <= is_terminal(next_state);
      passed    <= (next_state == PASS);
      timeout   <= (next_state == TIMEOUT);
    end
  end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Self-checking bench for sim_run_ctrl: directed scenarios plus a randomized
// phase, all compared every cycle against a behavioural run model.
module tb_sim_run_ctrl;

  import sim_run_pkg::*;

  localparam int RST_N  = RUN_RST_CYCLES;
  localparam int TO_N   = RUN_TIMEOUT_CYCLES;
  localparam int CNT_W  = 32;

  localparam int V_NONE    = 0;
  localparam int V_PASS    = 1;
  localparam int V_FAIL    = 2;
  localparam int V_TIMEOUT = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             done_i = 1'b0;
  logic             fail_i = 1'b0;
  logic             dut_rst_n;
  logic             running;
  logic             finished;
  logic             passed;
  logic             timeout;
  logic [CNT_W-1:0] cycle_cnt;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Behavioural model state
  bit m_valid   = 1'b0;
  bit m_started = 1'b0;
  int m_hold    = 0;
  int m_cnt     = 0;
  int m_verdict = V_NONE;

  sim_run_ctrl #(
    .RST_CYCLES     (RST_N),
    .TIMEOUT_CYCLES (TO_N),
    .CNT_W          (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .done_i    (done_i),
    .fail_i    (fail_i),
    .dut_rst_n (dut_rst_n),
    .running   (running),
    .finished  (finished),
    .passed    (passed),
    .timeout   (timeout),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Run model: a count of reset edges, a count of run edges, and a verdict.
  always @(posedge clk) begin
    if (rst) begin
      m_valid   = 1'b1;
      m_started = 1'b0;
      m_hold    = 0;
      m_cnt     = 0;
      m_verdict = V_NONE;
    end else if (!m_started) begin
      m_hold++;
      if (m_hold == RST_N) m_started = 1'b1;
    end else if (m_verdict == V_NONE) begin
      if (fail_i) m_verdict = V_FAIL;
      else if (done_i) m_verdict = V_PASS;
      else begin
        m_cnt++;
        if (m_cnt == TO_N) m_verdict = V_TIMEOUT;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("dut_rst_n", 32'(dut_rst_n), 32'(m_started));
      check("running",   32'(running),   32'(m_started && m_verdict == V_NONE));
      check("finished",  32'(finished),  32'(m_verdict != V_NONE));
      check("passed",    32'(passed),    32'(m_verdict == V_PASS));
      check("timeout",   32'(timeout),   32'(m_verdict == V_TIMEOUT));
      check("cycle_cnt", cycle_cnt,      32'(m_cnt));
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input bit r, input bit d, input bit f);
    rst    = r;
    done_i = d;
    fail_i = f;
  endtask

  task automatic check_output(input string tag, input bit e_rst_n, input bit e_run,
                              input bit e_fin, input bit e_pass, input bit e_to, input int e_cnt);
    check({tag, ".dut_rst_n"}, 32'(dut_rst_n), 32'(e_rst_n));
    check({tag, ".running"},   32'(running),   32'(e_run));
    check({tag, ".finished"},  32'(finished),  32'(e_fin));
    check({tag, ".passed"},    32'(passed),    32'(e_pass));
    check({tag, ".timeout"},   32'(timeout),   32'(e_to));
    check({tag, ".cycle_cnt"}, cycle_cnt,      32'(e_cnt));
  endtask

  // Pulse rst for one edge, then wait out the full hold so the DUT sits in RUN with count 0.
  task automatic reset_to_run();
    apply_stimulus(1, 0, 0);
    wait_edges(1);
    apply_stimulus(0, 0, 0);
    wait_edges(RST_N);
  endtask

  initial begin
    // 1: default timeout run
    apply_stimulus(1, 0, 0);
    wait_edges(3);
    check_output("s1_reset", 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0);
    wait_edges(RST_N - 1);
    check_output("s1_hold_last", 0, 0, 0, 0, 0, 0);
    wait_edges(1);
    check_output("s1_run_entry", 1, 1, 0, 0, 0, 0);
    wait_edges(TO_N - 1);
    check_output("s1_pre_timeout", 1, 1, 0, 0, 0, 19);
    wait_edges(1);
    check_output("s1_timeout", 1, 0, 1, 0, 1, 20);
    check("s1_model_cnt", 32'(m_cnt), 32'd20);
    wait_edges(3);
    check_output("s1_timeout_held", 1, 0, 1, 0, 1, 20);

    // 2: done pulse at run cycle 5
    reset_to_run();
    wait_edges(5);
    apply_stimulus(0, 1, 0);
    wait_edges(1);
    apply_stimulus(0, 0, 0);
    check_output("s2_pass", 1, 0, 1, 1, 0, 5);
    wait_edges(10);
    check_output("s2_pass_held", 1, 0, 1, 1, 0, 5);
    check("s2_model_verdict", 32'(m_verdict), 32'(V_PASS));

    // 3: done and fail together at run cycle 7
    reset_to_run();
    wait_edges(7);
    apply_stimulus(0, 1, 1);
    wait_edges(1);
    apply_stimulus(0, 0, 0);
    check_output("s3_fail", 1, 0, 1, 0, 0, 7);
    apply_stimulus(0, 1, 0);
    wait_edges(2);
    apply_stimulus(0, 0, 0);
    check_output("s3_fail_sticky", 1, 0, 1, 0, 0, 7);

    // 4: done on the timeout edge
    reset_to_run();
    wait_edges(TO_N - 1);
    apply_stimulus(0, 1, 0);
    wait_edges(1);
    apply_stimulus(0, 0, 0);
    check_output("s4_pass_at_edge", 1, 0, 1, 1, 0, 19);

    // 5: done held during hold is ignored
    apply_stimulus(1, 0, 0);
    wait_edges(1);
    apply_stimulus(0, 1, 0);
    wait_edges(RST_N - 1);
    check_output("s5_hold_done", 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0);
    wait_edges(1);
    check_output("s5_run_entry", 1, 1, 0, 0, 0, 0);
    wait_edges(TO_N);
    check_output("s5_timeout", 1, 0, 1, 0, 1, 20);

    // 6: rst mid-run and again in PASS
    reset_to_run();
    wait_edges(12);
    apply_stimulus(1, 0, 0);
    wait_edges(1);
    apply_stimulus(0, 0, 0);
    check_output("s6_mid_reset", 0, 0, 0, 0, 0, 0);
    wait_edges(RST_N - 1);
    check_output("s6_rehold", 0, 0, 0, 0, 0, 0);
    wait_edges(1);
    check_output("s6_rerun", 1, 1, 0, 0, 0, 0);
    wait_edges(3);
    apply_stimulus(0, 1, 0);
    wait_edges(1);
    apply_stimulus(0, 0, 0);
    check_output("s6_pass", 1, 0, 1, 1, 0, 3);
    wait_edges(2);
    apply_stimulus(1, 0, 0);
    wait_edges(1);
    apply_stimulus(0, 0, 0);
    check_output("s6_pass_reset", 0, 0, 0, 0, 0, 0);
    wait_edges(RST_N);
    check_output("s6_rerun2", 1, 1, 0, 0, 0, 0);

    // Randomized phase: sparse done/fail/rst so runs end in every way
    for (int i = 0; i < 1500; i++) begin
      apply_stimulus($urandom_range(0, 79) == 0,
                     $urandom_range(0, 24) == 0,
                     $urandom_range(0, 39) == 0);
      wait_edges(1);
    end
    apply_stimulus(0, 0, 0);
    wait_edges(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
